mem_io_responder: RTL and testbench

- Bus responder on the far end of the CPU byte-wide memory port (address, write strobe, data in/out, io_buffer_full).
- Provides 2^RAM_ADDR_WIDTH bytes of RAM and the memory-mapped I/O block: UART TX with FIFO, UART RX byte port, free-running cycle counter, program-stop flag.
- Sits between the cpu top and the board/testbench UART.

---
 rtl/mem_io_responder_if.sv | 34 +++
 rtl/mem_io_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_io_responder.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_io_responder_if.sv
// mem_io_responder_if
// CPU byte-wide memory port plus the UART TX/RX byte handshakes that the
// memory/I-O responder serves. The master side is the CPU and board
// environment. The slave side is mem_io_responder.
interface mem_io_responder_if;

   // CPU memory port
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [7:0]  cpu_dout;
   logic [7:0]  mem_din;
   logic        io_buffer_full;

   // UART transmit stream (responder is the source)
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   // UART receive byte port (responder consumes)
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_pop;

   modport master (
      output mem_a, mem_wr, cpu_dout, tx_ready, rx_data, rx_valid,
      input  mem_din, io_buffer_full, tx_data, tx_valid, rx_pop
   );

   modport slave (
      input  mem_a, mem_wr, cpu_dout, tx_ready, rx_data, rx_valid,
      output mem_din, io_buffer_full, tx_data, tx_valid, rx_pop
   );

endinterface

// File: rtl/mem_io_responder.sv
// mem_io_responder
// Far end of the CPU byte-wide memory port. It provides these functions:
//   - 2^RAM_ADDR_WIDTH bytes of RAM with a 1-cycle registered read.
//   - Memory-mapped I/O when mem_a[17:16] == 2'b11:
//       0x30000  read: UART RX byte (pops it).  write: TX byte (0x00 ignored).
//       0x30004  read: counter[7:0] and snapshot of the counter.
//                write: program stop, which also queues 0x00 on TX.
//       0x30005..0x30007  read: snapshot bytes 1..3.
//   - A TX FIFO with a registered early-warning io_buffer_full flag.
// Optional build macro MEM_ADDR_CHECK_EN adds a sticky addr_err output. When it
// is set, out-of-range RAM accesses are blocked: reads return 0 and writes are
// dropped. Without the macro, those addresses alias modulo the RAM size.
module mem_io_responder #(
   parameter int RAM_ADDR_WIDTH = 17,
   parameter int TX_DEPTH_LOG2  = 3,
   parameter int FULL_MARGIN    = 2
) (
   input  logic               clk_in,
   input  logic               rst_in,
   mem_io_responder_if.slave  bus,
   output logic               prog_done,
   output logic               tx_overflow
`ifdef MEM_ADDR_CHECK_EN
   ,
   output logic               addr_err
`endif
);

   localparam int RAM_SIZE = 1 << RAM_ADDR_WIDTH;
   localparam int PTR_W    = TX_DEPTH_LOG2;
   localparam int CNT_W    = TX_DEPTH_LOG2 + 1;

   localparam logic [CNT_W-1:0] DEPTH      = CNT_W'(1 << TX_DEPTH_LOG2);
   localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'((1 << TX_DEPTH_LOG2) - FULL_MARGIN);

   localparam logic [15:0] IO_UART  = 16'h0000;
   localparam logic [15:0] IO_CNT0  = 16'h0004;
   localparam logic [15:0] IO_SNAP1 = 16'h0005;
   localparam logic [15:0] IO_SNAP2 = 16'h0006;
   localparam logic [15:0] IO_SNAP3 = 16'h0007;

   // Address decode
   logic                      io_sel;
   logic                      addr_bad;
   logic [15:0]               io_off;
   logic [RAM_ADDR_WIDTH-1:0] ram_idx;
   logic                      ram_rd;
   logic                      ram_wr;
   logic                      io_rd;
   logic                      io_wr;

   // Storage and I/O state
   logic [7:0]                ram [0:RAM_SIZE-1];
   logic [7:0]                mem_din_q;
   logic [31:0]               counter;
   logic [31:0]               snapshot;
   logic [7:0]                io_rd_data;

   // TX FIFO
   logic [7:0]                fifo_mem [0:(1 << TX_DEPTH_LOG2)-1];
   logic [PTR_W-1:0]          head;
   logic [PTR_W-1:0]          tail;
   logic [CNT_W-1:0]          count;
   logic [CNT_W-1:0]          count_next;
   logic                      full_q;
   logic                      push_req;
   logic                      push_ok;
   logic                      tx_pop;
   logic                      ovf_set;
   logic [7:0]                push_data;

   // Split the CPU address into RAM or I/O space and flag bad accesses
   always_comb begin
      io_sel  = (bus.mem_a[17:16] == 2'b11);
      io_off  = bus.mem_a[15:0];
      ram_idx = bus.mem_a[RAM_ADDR_WIDTH-1:0];
`ifdef MEM_ADDR_CHECK_EN
      addr_bad = (!io_sel && ({1'b0, bus.mem_a[17:0]} >= 19'(RAM_SIZE)))
               || (bus.mem_a[31:18] != 14'd0);
`else
      addr_bad = 1'b0;
`endif
      ram_rd = !io_sel && !bus.mem_wr && !addr_bad;
      ram_wr = !io_sel &&  bus.mem_wr && !addr_bad;
      io_rd  =  io_sel && !bus.mem_wr && !addr_bad;
      io_wr  =  io_sel &&  bus.mem_wr && !addr_bad;
   end

`ifndef MEM_ADDR_CHECK_EN
   logic unused_hi_addr;
   assign unused_hi_addr = ^bus.mem_a[31:18];
`endif

   // I/O read mux; RX byte is consumed on the same cycle it is read
   always_comb begin
      io_rd_data = 8'h00;
      bus.rx_pop = 1'b0;
      if (io_rd) begin
         case (io_off)
            IO_UART: begin
               if (bus.rx_valid) begin
                  io_rd_data = bus.rx_data;
                  bus.rx_pop = 1'b1;
               end
            end
            IO_CNT0:  io_rd_data = counter[7:0];
            IO_SNAP1: io_rd_data = snapshot[15:8];
            IO_SNAP2: io_rd_data = snapshot[23:16];
            IO_SNAP3: io_rd_data = snapshot[31:24];
            default:  io_rd_data = 8'h00;
         endcase
      end
   end

   // RAM write port; contents deliberately survive reset
   always_ff @(posedge clk_in) begin
      if (ram_wr) begin
         ram[ram_idx] <= bus.cpu_dout;
      end
   end

   // Registered read data; write cycles leave the previous value in place
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         mem_din_q <= 8'h00;
      end else if (!bus.mem_wr) begin
         if (ram_rd) begin
            mem_din_q <= ram[ram_idx];
         end else if (io_rd) begin
            mem_din_q <= io_rd_data;
         end else begin
            mem_din_q <= 8'h00;
         end
      end
   end

   assign bus.mem_din = mem_din_q;

   // Free-running cycle counter and the snapshot taken when byte 0 is read
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         counter  <= 32'd0;
         snapshot <= 32'd0;
      end else begin
         counter <= counter + 32'd1;
         if (io_rd && io_off == IO_CNT0) begin
            snapshot <= counter;
         end
      end
   end

   // Program-stop flag stays set until reset
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         prog_done <= 1'b0;
      end else if (io_wr && io_off == IO_CNT0) begin
         prog_done <= 1'b1;
      end
   end

   // TX FIFO push/pop decisions and the occupancy after this edge
   always_comb begin
      push_req   = io_wr && ((io_off == IO_UART && bus.cpu_dout != 8'h00)
                          || io_off == IO_CNT0);
      push_data  = (io_off == IO_CNT0) ? 8'h00 : bus.cpu_dout;
      tx_pop     = (count != '0) && bus.tx_ready;
      push_ok    = push_req && ((count != DEPTH) || tx_pop);
      ovf_set    = push_req && (count == DEPTH) && !tx_pop;
      count_next = count;
      if (push_ok && !tx_pop) begin
         count_next = count + CNT_W'(1);
      end else if (!push_ok && tx_pop) begin
         count_next = count - CNT_W'(1);
      end
   end

   // TX FIFO storage; no reset needed since count gates visibility
   always_ff @(posedge clk_in) begin
      if (push_ok) begin
         fifo_mem[tail] <= push_data;
      end
   end

   // TX FIFO pointers, occupancy, nearly-full flag and overflow sticky bit
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         full_q      <= 1'b0;
         tx_overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            tail <= tail + PTR_W'(1);
         end
         if (tx_pop) begin
            head <= head + PTR_W'(1);
         end
         count  <= count_next;
         full_q <= (count_next >= FULL_LEVEL);
         if (ovf_set) begin
            tx_overflow <= 1'b1;
         end
      end
   end

   assign bus.tx_valid       = (count != '0);
   assign bus.tx_data        = fifo_mem[head];
   assign bus.io_buffer_full = full_q;

`ifdef MEM_ADDR_CHECK_EN
   // Sticky record of any access outside the decoded space
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         addr_err <= 1'b0;
      end else if (addr_bad) begin
         addr_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder
// Scoreboard bench for mem_io_responder. Stimulus pushes the expected read
// bytes and the expected TX stream into queues. A negedge monitor pops and
// compares them whenever the DUT presents read data or a TX handshake.
module tb_mem_io_responder;

   localparam logic [31:0] IDLE_ADDR = 32'h0003_FFF0;

   logic clk_in = 1'b0;
   logic rst_in;
   logic prog_done;
   logic tx_overflow;
`ifdef MEM_ADDR_CHECK_EN
   logic addr_err;
`endif

   mem_io_responder_if bus ();

   mem_io_responder dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .bus         (bus),
      .prog_done   (prog_done),
      .tx_overflow (tx_overflow)
`ifdef MEM_ADDR_CHECK_EN
      ,
      .addr_err    (addr_err)
`endif
   );

   always #5 clk_in = ~clk_in;

   int        checks = 0;
   int        passes = 0;
   logic [7:0] rd_q [$];
   logic [7:0] tx_q [$];
   logic      rd_active = 1'b0;
   logic      rd_pending = 1'b0;
   logic [31:0] tb_cnt;

   // Reference cycle counter: counts clocks since reset was released
   always @(posedge clk_in or posedge rst_in) begin
      if (rst_in) tb_cnt <= 32'd0;
      else        tb_cnt <= tb_cnt + 32'd1;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic reportFail(input string name);
      checks++;
      $display("[TB] FAIL %s at %0t", name, $time);
   endtask

   // Monitor: read data appears one edge after a read; TX bytes on handshake
   always @(negedge clk_in) begin
      if (rst_in) begin
         rd_pending = 1'b0;
      end else begin
         if (rd_pending) begin
            if (rd_q.size() == 0) reportFail("mem_din_unexpected");
            else checkOutput("mem_din", {24'd0, bus.mem_din}, {24'd0, rd_q.pop_front()});
         end
         rd_pending = rd_active;
         if (bus.tx_valid && bus.tx_ready) begin
            if (tx_q.size() == 0) reportFail("tx_unexpected_byte");
            else checkOutput("tx_data", {24'd0, bus.tx_data}, {24'd0, tx_q.pop_front()});
         end
      end
   end

   task automatic drive(input logic wr, input logic [31:0] addr,
                        input logic [7:0] data, input logic [7:0] exp);
      bus.mem_wr   = wr;
      bus.mem_a    = addr;
      bus.cpu_dout = data;
      rd_active    = !wr;
      if (!wr) rd_q.push_back(exp);
   endtask

   task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                input logic [7:0] data, input logic [7:0] exp);
      @(posedge clk_in);
      #1;
      drive(wr, addr, data, exp);
   endtask

   task automatic applyIdle();
      applyStimulus(1'b1, IDLE_ADDR, 8'h00, 8'h00);
   endtask

   // Hard stop if something hangs
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout");
      $display("%0d/%0d checks passed", passes, checks + 1);
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int guard;
      rst_in       = 1'b1;
      bus.mem_a    = IDLE_ADDR;
      bus.mem_wr   = 1'b1;
      bus.cpu_dout = 8'h00;
      bus.tx_ready = 1'b0;
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      $display("[TB] reset state");
      checkOutput("rst_mem_din", {24'd0, bus.mem_din}, 32'h0);
      checkOutput("rst_tx_valid", {31'd0, bus.tx_valid}, 32'h0);
      checkOutput("rst_io_full", {31'd0, bus.io_buffer_full}, 32'h0);
      checkOutput("rst_prog_done", {31'd0, prog_done}, 32'h0);
      checkOutput("rst_tx_overflow", {31'd0, tx_overflow}, 32'h0);
      rst_in = 1'b0;

      $display("[TB] RAM write/read");
      applyStimulus(1'b1, 32'h0000_0010, 8'hA5, 8'h00);
      applyStimulus(1'b0, 32'h0000_0010, 8'h00, 8'hA5);
      applyStimulus(1'b1, 32'h0001_FFFF, 8'h5A, 8'h00);
      applyStimulus(1'b0, 32'h0001_FFFF, 8'h00, 8'h5A);
      applyStimulus(1'b1, 32'h0000_0020, 8'h3C, 8'h00);
      applyIdle();
      @(negedge clk_in);
      checkOutput("din_hold_on_write", {24'd0, bus.mem_din}, 32'h5A);
      applyStimulus(1'b0, 32'h0000_0020, 8'h00, 8'h3C);
`ifdef MEM_ADDR_CHECK_EN
      applyStimulus(1'b0, 32'h0002_0010, 8'h00, 8'h00);
      applyIdle();
      @(negedge clk_in);
      checkOutput("addr_err", {31'd0, addr_err}, 32'h1);
`else
      applyStimulus(1'b0, 32'h0002_0010, 8'h00, 8'hA5);
      applyIdle();
`endif

      $display("[TB] TX zero filter");
      bus.tx_ready = 1'b1;
      tx_q.push_back(8'h48);
      tx_q.push_back(8'h69);
      applyStimulus(1'b1, 32'h0003_0000, 8'h48, 8'h00);
      applyStimulus(1'b1, 32'h0003_0000, 8'h00, 8'h00);
      applyStimulus(1'b1, 32'h0003_0000, 8'h69, 8'h00);
      repeat (3) applyIdle();
      bus.tx_ready = 1'b0;
      applyIdle();

      $display("[TB] TX fill, nearly-full flag, wrap, overflow");
      for (int i = 0; i < 8; i++) begin
         tx_q.push_back(8'h11 + 8'(i));
         applyStimulus(1'b1, 32'h0003_0000, 8'h11 + 8'(i), 8'h00);
         @(negedge clk_in);
         if (i == 5) checkOutput("io_full_after5", {31'd0, bus.io_buffer_full}, 32'h0);
         if (i == 6) checkOutput("io_full_after6", {31'd0, bus.io_buffer_full}, 32'h1);
      end
      applyIdle();
      @(negedge clk_in);
      checkOutput("head_at_full", {24'd0, bus.tx_data}, 32'h11);
      checkOutput("no_ovf_at_8", {31'd0, tx_overflow}, 32'h0);
      for (int j = 0; j < 4; j++) begin
         tx_q.push_back(8'h21 + 8'(j));
         applyStimulus(1'b1, 32'h0003_0000, 8'h21 + 8'(j), 8'h00);
         bus.tx_ready = 1'b1;
      end
      applyStimulus(1'b1, 32'h0003_0000, 8'h25, 8'h00);
      bus.tx_ready = 1'b0;
      @(negedge clk_in);
      checkOutput("no_ovf_push_pop", {31'd0, tx_overflow}, 32'h0);
      checkOutput("io_full_push_pop", {31'd0, bus.io_buffer_full}, 32'h1);
      applyIdle();
      @(negedge clk_in);
      checkOutput("ovf_set", {31'd0, tx_overflow}, 32'h1);
      bus.tx_ready = 1'b1;
      repeat (10) applyIdle();
      @(negedge clk_in);
      checkOutput("drained_valid", {31'd0, bus.tx_valid}, 32'h0);
      checkOutput("drained_io_full", {31'd0, bus.io_buffer_full}, 32'h0);

      $display("[TB] RX port and program stop");
      applyStimulus(1'b0, 32'h0003_0000, 8'h00, 8'h37);
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h37;
      @(negedge clk_in);
      checkOutput("rx_pop_on_read", {31'd0, bus.rx_pop}, 32'h1);
      applyIdle();
      @(negedge clk_in);
      checkOutput("rx_pop_idle", {31'd0, bus.rx_pop}, 32'h0);
      bus.rx_valid = 1'b0;
      applyStimulus(1'b0, 32'h0003_0000, 8'h00, 8'h00);
      @(negedge clk_in);
      checkOutput("rx_pop_empty", {31'd0, bus.rx_pop}, 32'h0);
      applyStimulus(1'b0, 32'h0000_0010, 8'h00, 8'hA5);
      applyStimulus(1'b0, 32'h0003_0008, 8'h00, 8'h00);
      tx_q.push_back(8'h00);
      applyStimulus(1'b1, 32'h0003_0004, 8'h55, 8'h00);
      applyIdle();
      @(negedge clk_in);
      checkOutput("prog_done_set", {31'd0, prog_done}, 32'h1);
      repeat (2) applyIdle();

      $display("[TB] mid-run reset");
      applyStimulus(1'b0, 32'h0000_0010, 8'h00, 8'hA5);
      applyIdle();
      applyIdle();
      @(negedge clk_in);
      rst_in = 1'b1;
      #1;
      checkOutput("midrst_mem_din", {24'd0, bus.mem_din}, 32'h0);
      checkOutput("midrst_prog_done", {31'd0, prog_done}, 32'h0);
      checkOutput("midrst_tx_overflow", {31'd0, tx_overflow}, 32'h0);
      checkOutput("midrst_tx_valid", {31'd0, bus.tx_valid}, 32'h0);
      @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      applyStimulus(1'b0, 32'h0000_0010, 8'h00, 8'hA5);
      applyIdle();

      $display("[TB] counter snapshot");
      guard = 0;
      while (tb_cnt != 32'h0000_01FF && guard < 5000) begin
         @(posedge clk_in);
         #1;
         guard++;
      end
      if (tb_cnt != 32'h0000_01FF) begin
         reportFail("counter_wait_budget");
      end else begin
         drive(1'b0, 32'h0003_0004, 8'h00, 8'hFF);
         applyStimulus(1'b0, 32'h0003_0005, 8'h00, 8'h01);
         applyStimulus(1'b0, 32'h0003_0006, 8'h00, 8'h00);
         applyStimulus(1'b0, 32'h0003_0007, 8'h00, 8'h00);
      end
      repeat (3) applyIdle();
      @(negedge clk_in);
      checkOutput("rd_queue_drained", rd_q.size(), 32'd0);
      checkOutput("tx_queue_drained", tx_q.size(), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
